nibble_serial_addsub: RTL
=========================

// Module: nibble_serial_addsub
// PURPOSE
//  Multi-cycle WIDTH-bit adder/subtractor that reuses one adder_4bits instance,
//  processing one nibble per clock, LSB nibble first, with a registered ripple carry.
//  Trades latency for area; serves wide ALU ops in the lab datapath.
//  start/busy/done handshake toward the issuing controller.
// PARAMETERS
//  WIDTH    16  operand/result width; multiple of 4, >= 8
//  NIB      WIDTH/4  localparam: nibble count = RUN cycles per op
// PORTS
//  clk    in   1      sole clock, rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  sub    in   1      0: a+b, 1: a-b; sampled with start
//  a      in   WIDTH  operand A; sampled with start
//  b      in   WIDTH  operand B; sampled with start
//  busy   out  1      high whenever state != IDLE
//  done   out  1      one-cycle pulse; sum/co/ovf valid in this cycle
//  sum    out  WIDTH  result; registered
//  co     out  1      carry out of MSB (sub: 1 = no borrow, a >= b unsigned)
//  ovf    out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, sum=0, co=0, ovf=0; index and carry cleared.
//  - FSM states IDLE -> RUN -> DONE -> IDLE.
//    IDLE: start=1 captures A=a, B=(sub ? ~b : b), carry=sub, idx=0; go to RUN.
//          start=0: stay in IDLE; outputs hold.
//    RUN:  one nibble per cycle. Adder inputs A[4*idx+:4], B[4*idx+:4], ci=carry.
//          Write s into acc[4*idx+:4]; carry <= adder co; idx++.
//          After idx==NIB-1 is processed, go to DONE.
//    DONE: done=1 for exactly one cycle; return to IDLE.
//  - sum/co/ovf update only on the edge entering DONE and hold until the next DONE.
//    Between DONEs they show the previous result; partial nibbles never reach sum.
//  - sum is the internal accumulator acc; co is the final carry.
//  - ovf = (A[MSB]==B[MSB]) & (acc[MSB]!=A[MSB]), using the inverted B for sub.
//  - Timing (start high in cycle 0):
//    busy high in cycles 1..NIB+1; done and results in cycle NIB+1 (5 for WIDTH=16).
//    Back-to-back issue period is NIB+2 cycles.
//  - start while busy (RUN or DONE): ignored, not queued.
//    a/b/sub changes while busy have no effect.
//  - start in the cycle after done (state IDLE): accepted normally.
//  - Carry chain across nibbles is strictly through the carry register.
//    Combinational path is limited to one adder_4bits per cycle.
//  - rst mid-operation wins over all other inputs: next cycle IDLE, busy=0.
//    No done pulse; sum/co/ovf forced to 0.
//  - Width arithmetic: results are modulo 2^WIDTH; no sign extension.
// TESTING  (WIDTH=16 unless noted)
//  1. add a=0x1234 b=0x0FFF -> cycle 5: done=1, sum=0x2233, co=0, ovf=0; busy 1..5 only.
//  2. add 0xFFFF+0x0001 -> sum=0x0000, co=1, ovf=0 (carry rippled through all 4 nibbles);
//     add 0x7FFF+0x0001 -> sum=0x8000, co=0, ovf=1.
//  3. sub 0x0005-0x0007 -> sum=0xFFFE, co=0, ovf=0;
//     sub 0x8000-0x0001 -> sum=0x7FFF, co=1, ovf=1.
//  4. start pulsed in cycles 2 and 5 of an op, with a/b changed mid-op ->
//     single done, result of the originally captured operands only.
//  5. rst asserted in RUN cycle 3 -> cycle 4: busy=0, sum=0, co=0, ovf=0, no done ever;
//     a fresh start afterwards completes normally.
//  6. start held high continuously -> done every 6 cycles, each result correct;
//     repeat one add/sub case with WIDTH=8 -> done in cycle 3.

Source files
------------

// File: rtl/nibble_serial_addsub.sv
// -----------------------------------------------------------------------------
// nibble_serial_addsub
//   Multi-cycle WIDTH-bit adder/subtractor built around a single 4-bit adder.
//   One nibble is processed per clock, least-significant nibble first. The carry
//   between nibbles is held in a register, so the longest combinational path is
//   one 4-bit add. Subtraction is done as A + ~B + 1.
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : operation request, accepted only while idle
//   sub    : 0 = a+b, 1 = a-b (captured with start)
//   a, b   : operands (captured with start)
//   busy   : high while an operation is in flight (RUN or DONE)
//   done   : one-cycle pulse, sum/co/ovf refreshed in this cycle
//   sum    : registered result, holds until the next done
//   co     : carry out of the MSB (for sub: 1 = no borrow)
//   ovf    : two's-complement overflow
// -----------------------------------------------------------------------------

// Plain 4-bit ripple adder; the only adder in the datapath.
module adder_4bits (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);
    assign {co_o, s_o} = 5'(a_i) + 5'(b_i) + 5'(ci_i);
endmodule

module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  op_a_q;
    logic [WIDTH-1:0]  op_b_q;     // already inverted for subtraction
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  acc_d;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic              done_q;
    logic [WIDTH-1:0]  sum_q;
    logic              co_q;
    logic              ovf_q;

    logic [3:0]        nib_a [NIB];
    logic [3:0]        nib_b [NIB];
    logic [3:0]        add_s;
    logic              add_co;
    logic              ovf_d;

    // Split captured operands into nibbles and build the accumulator update:
    // only the nibble selected by idx_q takes the fresh adder result.
    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_nib
            assign nib_a[gi] = op_a_q[4*gi +: 4];
            assign nib_b[gi] = op_b_q[4*gi +: 4];
            assign acc_d[4*gi +: 4] = (idx_q == IDXW'(gi)) ? add_s : acc_q[4*gi +: 4];
        end
    endgenerate

    adder_4bits u_adder (
        .a_i  (nib_a[idx_q]),
        .b_i  (nib_b[idx_q]),
        .ci_i (carry_q),
        .s_o  (add_s),
        .co_o (add_co)
    );

    // Uses the inverted B, so the same rule covers add and subtract.
    assign ovf_d = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &
                   (acc_d[WIDTH-1] != op_a_q[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_a_q  <= a;
                        op_b_q  <= sub ? ~b : b;
                        carry_q <= sub;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= add_co;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == IDXW'(NIB - 1)) begin
                        // Results become visible only once the last nibble is in.
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        sum_q   <= acc_d;
                        co_q    <= add_co;
                        ovf_q   <= ovf_d;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

endmodule
